// File: rtl/clk_phase_pkg.sv
// clk_phase_pkg: shared widths and the phase-decode rule for clk_phase_gen.
package clk_phase_pkg;

    // Bits needed to count slots 0 .. 2*num_out-1.
    function automatic int slot_width(input int num_out);
        return $clog2(2 * num_out);
    endfunction

    // Bits needed to count 0 .. lock_periods inclusive.
    function automatic int lock_width(input int lock_periods);
        return $clog2(lock_periods + 1);
    endfunction

    // Output k is high while (slot - k) mod 2*num_out is in the first half of the period.
    function automatic logic phase_high(input int slot, input int k, input int num_out);
        int diff;
        diff = slot - k;
        if (diff < 0) begin
            diff = diff + 2 * num_out;
        end
        return diff < num_out;
    endfunction

endpackage

// File: rtl/clk_lock_mon.sv
// clk_lock_mon: counts consecutive output periods that kept the same divide
// ratio and raises locked once LOCK_PERIODS of them have completed.
module clk_lock_mon
    import clk_phase_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int LOCK_PERIODS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wrap,
    input  logic [CNT_W-1:0] div_in,
    input  logic [CNT_W-1:0] div_q,
    output logic             locked
);

    localparam int              LOCK_W   = lock_width(LOCK_PERIODS);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_PERIODS);

    logic [LOCK_W-1:0] cnt_q, cnt_d;
    logic              locked_q, locked_d;

    // On each period wrap: a new ratio restarts the count, an unchanged one extends it.
    always_comb begin
        cnt_d    = cnt_q;
        locked_d = locked_q;
        if (wrap) begin
            if (div_in != div_q) begin
                cnt_d    = '0;
                locked_d = 1'b0;
            end else begin
                if (cnt_q != LOCK_MAX) begin
                    cnt_d = cnt_q + LOCK_W'(1);
                end
                locked_d = (cnt_d == LOCK_MAX);
            end
        end
    end

    // Lock counter and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

    assign locked = locked_q;

endmodule

// File: rtl/clk_phase_gen.sv
// clk_phase_gen: NUM_OUT phase-staggered square clocks with rise/fall enables
// and a lock flag, all derived from CLK_IN1.
// Optional feature: define CLK_STRETCH_EN to let STRETCH hold the current slot;
// without it STRETCH is ignored and the period length is always exact.
module clk_phase_gen
    import clk_phase_pkg::*;
#(
    parameter int NUM_OUT      = 4,
    parameter int CNT_W        = 8,
    parameter int LOCK_PERIODS = 16
) (
    input  logic               CLK_IN1,
    input  logic               RESET,
    input  logic [CNT_W-1:0]   DIV,
    input  logic               STRETCH,
    output logic [NUM_OUT-1:0] CLK_OUT,
    output logic [NUM_OUT-1:0] CLK_EN_RISE,
    output logic [NUM_OUT-1:0] CLK_EN_FALL,
    output logic               LOCKED
);

    localparam int                SLOT_W    = slot_width(NUM_OUT);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(2 * NUM_OUT - 1);

    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [CNT_W-1:0]   sub_q, sub_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic [NUM_OUT-1:0] out_q, out_d;
    logic [NUM_OUT-1:0] rise_q, rise_d;
    logic [NUM_OUT-1:0] fall_q, fall_d;
    logic               locked_q, locked_d;

    logic               hold;
    logic               at_end;
    logic               wrap;
    logic               lock_state;
    logic [NUM_OUT-1:0] phase;

`ifdef CLK_STRETCH_EN
    assign hold = STRETCH;
`else
    logic unused_stretch;
    assign unused_stretch = STRETCH;
    assign hold           = 1'b0;
`endif

    // A slot ends when sub reaches div_q; the period wraps after the last slot.
    assign at_end = (sub_q == div_q);
    assign wrap   = at_end && !hold && (slot_q == SLOT_LAST);

    // Slot/sub counters; DIV is only taken on at a period wrap.
    always_comb begin
        sub_d  = sub_q;
        slot_d = slot_q;
        div_d  = div_q;
        if (at_end) begin
            if (!hold) begin
                sub_d = '0;
                if (slot_q == SLOT_LAST) begin
                    slot_d = '0;
                    div_d  = DIV;
                end else begin
                    slot_d = slot_q + SLOT_W'(1);
                end
            end
        end else begin
            sub_d = sub_q + CNT_W'(1);
        end
    end

    // Decode the current slot into the level every phase output should take.
    always_comb begin
        phase = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            phase[k] = phase_high(int'(slot_q), k, NUM_OUT);
        end
    end

    // Registered outputs: edges are found against the level currently shown.
    always_comb begin
        out_d    = phase;
        rise_d   = phase & ~out_q;
        fall_d   = ~phase & out_q;
        locked_d = lock_state;
    end

    clk_lock_mon #(
        .CNT_W        (CNT_W),
        .LOCK_PERIODS (LOCK_PERIODS)
    ) u_lock_mon (
        .clk    (CLK_IN1),
        .rst    (RESET),
        .wrap   (wrap),
        .div_in (DIV),
        .div_q  (div_q),
        .locked (lock_state)
    );

    // State and output registers; reset abandons any period in progress.
    always_ff @(posedge CLK_IN1) begin
        if (RESET) begin
            slot_q   <= '0;
            sub_q    <= '0;
            div_q    <= DIV;
            out_q    <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            sub_q    <= sub_d;
            div_q    <= div_d;
            out_q    <= out_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            locked_q <= locked_d;
        end
    end

    assign CLK_OUT     = out_q;
    assign CLK_EN_RISE = rise_q;
    assign CLK_EN_FALL = fall_q;
    assign LOCKED      = locked_q;

endmodule

// File: tb/tb_clk_phase_gen.sv
// tb_clk_phase_gen: scoreboard bench for clk_phase_gen with a period-position
// reference model, directed timing checks and randomized stimulus.
`timescale 1ns/1ps
module tb_clk_phase_gen;

    localparam int N     = 2;
    localparam int CNT_W = 8;
    localparam int LP    = 16;
    localparam int EXP_W = 3 * N + 1;
`ifdef CLK_STRETCH_EN
    localparam bit STR_ON = 1'b1;
`else
    localparam bit STR_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic             clk     = 1'b0;
    logic             RESET   = 1'b1;
    logic [CNT_W-1:0] DIV     = '0;
    logic             STRETCH = 1'b0;
    logic [N-1:0]     CLK_OUT, CLK_EN_RISE, CLK_EN_FALL;
    logic             LOCKED;

    always #5 clk = ~clk;

    clk_phase_gen #(
        .NUM_OUT      (N),
        .CNT_W        (CNT_W),
        .LOCK_PERIODS (LP)
    ) dut (
        .CLK_IN1     (clk),
        .RESET       (RESET),
        .DIV         (DIV),
        .STRETCH     (STRETCH),
        .CLK_OUT     (CLK_OUT),
        .CLK_EN_RISE (CLK_EN_RISE),
        .CLK_EN_FALL (CLK_EN_FALL),
        .LOCKED      (LOCKED)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rise_prev = -1;
    int rise_last = -1;

    logic [EXP_W-1:0] exp_q[$];

    // ---------------- reference model ----------------
    // Position within the current output period, the ratio for that period,
    // the number of consecutive periods run at an unchanged ratio, and the
    // levels last shown (the model's outputs lag its position by one edge).
    int           m_pos  = 0;
    int           m_div  = 0;
    int           m_runs = 0;
    bit           m_lock = 1'b0;
    logic [N-1:0] m_prev = '0;

    function automatic void model_edge(input logic rst, input int div, input logic str);
        logic [N-1:0] lvl;
        int           slot_len;
        int           slot;
        if (rst) begin
            exp_q.push_back('0);
            m_pos  = 0;
            m_div  = div;
            m_runs = 0;
            m_lock = 1'b0;
            m_prev = '0;
        end else begin
            slot_len = m_div + 1;
            slot     = m_pos / slot_len;
            for (int k = 0; k < N; k++) begin
                lvl[k] = ((slot - k + 2 * N) % (2 * N)) < N;
            end
            exp_q.push_back({lvl, lvl & ~m_prev, ~lvl & m_prev, m_lock});
            m_prev = lvl;
            if (!(STR_ON && str && (m_pos % slot_len == slot_len - 1))) begin
                m_pos = m_pos + 1;
                if (m_pos == 2 * N * slot_len) begin
                    m_pos = 0;
                    if (div != m_div) begin
                        m_runs = 0;
                    end else if (m_runs < LP) begin
                        m_runs = m_runs + 1;
                    end
                    m_lock = (m_runs >= LP);
                    m_div  = div;
                end
            end
        end
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic rst, input int div, input logic str);
        @(negedge clk);
        RESET   = rst;
        DIV     = CNT_W'(div);
        STRETCH = str;
        model_edge(rst, div, str);
        @(posedge clk);
        #2;
        cyc++;
        if (CLK_EN_RISE[0]) begin
            rise_prev = rise_last;
            rise_last = cyc;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    int               mon_cyc = 0;
    logic [EXP_W-1:0] mon_exp;
    logic [EXP_W-1:0] mon_act;

    always @(posedge clk) begin
        #1;
        mon_cyc++;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {CLK_OUT, CLK_EN_RISE, CLK_EN_FALL, LOCKED};
            n_tests++;
            if (mon_act !== mon_exp) begin
                n_fail++;
                $display("FAIL sb cycle %0d {out,rise,fall,locked}: got %b expected %b",
                         mon_cyc, mon_act, mon_exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int first_lock;
        int fall_at;
        int rise_at;
        int cur_div;
        int prev_rise_seen;

        // Reset hold: outputs must read zero.
        repeat (3) step(1'b1, 0, 1'b0);
        check("reset_clk_out", int'(CLK_OUT), 0);
        check("reset_locked", int'(LOCKED), 0);

        // Lock latency with DIV=0: period is 2*N cycles, LOCKED at cycle LP*2*N.
        first_lock = -1;
        for (int i = 0; i < 200 && first_lock < 0; i++) begin
            step(1'b0, 0, 1'b0);
            if (i == 0) begin
                check("first_rise0", int'(CLK_EN_RISE), 1);
            end
            if (LOCKED) first_lock = i;
        end
        check("lock_cycle", first_lock, LP * 2 * N);
        repeat (10) step(1'b0, 0, 1'b0);
        check("lock_stays", int'(LOCKED), 1);

        // Ratio change mid-period: old ratio to the wrap, then unlock, then relock.
        while (m_pos != 1) step(1'b0, 0, 1'b0);
        fall_at = -1;
        rise_at = -1;
        for (int i = 1; i <= 600 && rise_at < 0; i++) begin
            step(1'b0, 3, 1'b0);
            if (fall_at < 0 && !LOCKED) fall_at = i;
            else if (fall_at >= 0 && LOCKED) rise_at = i;
        end
        check("div_change_fall", fall_at, 2 * N);
        check("div_change_relock", rise_at - fall_at, LP * 2 * N * 4);

        // Stretch: DIV=1, hold 5 cycles at the end of slot 1.
        repeat (2) step(1'b1, 1, 1'b0);
        repeat (2 * N * 2) step(1'b0, 1, 1'b0);
        while (m_pos != 3) step(1'b0, 1, 1'b0);
        repeat (5) step(1'b0, 1, 1'b1);
        prev_rise_seen = rise_last;
        for (int i = 0; i < 40 && rise_last == prev_rise_seen; i++) begin
            step(1'b0, 1, 1'b0);
        end
        check("stretch_period", rise_last - rise_prev, STR_ON ? 13 : 8);

        // Reset for one cycle in slot 3, then restart from slot 0.
        while (m_pos != 3 * 2) step(1'b0, 1, 1'b0);
        step(1'b1, 1, 1'b0);
        check("midreset_out", int'(CLK_OUT), 0);
        check("midreset_locked", int'(LOCKED), 0);
        step(1'b0, 1, 1'b0);
        check("restart_rise", int'(CLK_EN_RISE), 1);
        check("restart_out", int'(CLK_OUT), 1);

        // Randomized run: occasional ratio changes, stretch and resets.
        cur_div = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) cur_div = $urandom_range(0, 3);
            step(($urandom_range(0, 299) == 0), cur_div, ($urandom_range(0, 3) == 0));
        end

        // Long steady stretch-free run so the random section ends locked.
        for (int i = 0; i < (LP + 2) * 2 * N * 4; i++) begin
            step(1'b0, cur_div, 1'b0);
        end
        check("final_locked", int'(LOCKED), 1);

        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_phase_gen.md
# clk_phase_gen

Parametrised multi-phase clock-enable generator. It derives NUM_OUT phase-staggered square clocks, plus matching single-cycle rise and fall enables, from one master clock, and provides a lock indication. It sits directly downstream of the PLL wrapper and supersedes fixed PLL-only phase generation. Typical use is producing the CPU E/Q quadrature pair with a run-time divide ratio and MRDY-style clock stretching.

## Interface
Parameters:
- NUM_OUT, 4, number of phase outputs; must be ≥ 1
- CNT_W, 8, width of the slot-length divider
- LOCK_PERIODS, 16, number of complete output periods before LOCKED asserts; must be ≥ 1

Ports:
- CLK_IN1  in  1  master clock; all logic is on its rising edge
- RESET  in  1  synchronous, active-high reset
- DIV  in  CNT_W  slot length minus one, in master cycles
- STRETCH  in  1  holds the current slot while high
- CLK_OUT  out  NUM_OUT  phase square outputs
- CLK_EN_RISE  out  NUM_OUT  one-cycle pulse coincident with each CLK_OUT[k] 0→1
- CLK_EN_FALL  out  NUM_OUT  one-cycle pulse coincident with each CLK_OUT[k] 1→0
- LOCKED  out  1  outputs are running at a stable ratio

## Operation
- State:
  - slot counter `slot`, range 0..2·NUM_OUT−1
  - sub-counter `sub`, range 0..div_q
  - div_q, a DIV register
  - lock counter
- Decode: CLK_OUT[k] is high when (slot − k) mod 2·NUM_OUT < NUM_OUT. Each output has a 50% duty cycle, and output k lags output k−1 by one slot.
- Slot advance: `sub` increments each cycle. When sub == div_q and no hold applies, sub→0 and slot→slot+1, wrapping from 2·NUM_OUT−1 to 0.
- Period wrap is the slot 2·NUM_OUT−1 → 0 transition. At period wrap:
  - DIV is sampled into div_q.
  - If the sampled DIV ≠ div_q: LOCKED→0 and the lock counter clears.
  - Otherwise the lock counter increments, saturating. LOCKED→1 on the wrap that completes the LOCK_PERIODS-th period.
- DIV changes between wraps have no effect until the next wrap.
- Reset: slot=0, sub=0, lock counter=0, div_q←DIV. Held values during reset: CLK_OUT=0, CLK_EN_RISE=0, CLK_EN_FALL=0, LOCKED=0.
- A reset asserted mid-period abandons the period. The first post-reset period always starts at slot 0.

## Timing
- Outputs are registered, with one cycle of latency from state. On the first edge with RESET low, CLK_OUT[0]→1 and CLK_EN_RISE[0]=1.
- Each slot lasts DIV+1 cycles. One output period is 2·NUM_OUT·(DIV+1) cycles.
- DIV=0 gives a slot length of one cycle, and slot advances every cycle.
- CLK_EN_RISE[k] and CLK_EN_FALL[k] are high for exactly one cycle, in the cycle CLK_OUT[k] first shows its new level.
- STRETCH is evaluated only when sub == div_q. While it is high, sub and slot hold and no enable pulses fire. Release resumes the advance on the next edge.
- LOCKED rises in the same cycle as the CLK_OUT edges of slot 0 that follow the qualifying wrap.
- LOCKED falls in the first cycle of slot 0 after a DIV change.

## Configuration
- CLK_STRETCH_EN defined: STRETCH functions as described above.
- CLK_STRETCH_EN undefined: STRETCH is ignored and its hold logic is not compiled in. Period length is then always exact.

## Structure
- Package clk_phase_pkg holds:
  - the slot-counter width function, clog2(2·NUM_OUT)
  - the lock-counter width, clog2(LOCK_PERIODS+1)
  - the phase-decode function
- Sub-module clk_lock_mon holds the lock counter, the DIV-change compare and the LOCKED register. Its inputs are the wrap strobe, DIV and div_q.

## Test plan
- Basic quadrature. NUM_OUT=2, DIV=1, reset released → expected pattern with an 8-cycle period:
  - CLK_OUT[0] = 11110000
  - CLK_OUT[1] = 00111100
  - CLK_EN_RISE[0] at cycle 0, CLK_EN_RISE[1] at cycle 2
  - CLK_EN_FALL[0] at cycle 4, CLK_EN_FALL[1] at cycle 6
- Lock assertion. NUM_OUT=4, DIV=0, LOCK_PERIODS=16 → 8-cycle period; LOCKED rises at cycle 128 and stays high.
- DIV change. Change DIV 0→3 mid-period after lock → old ratio holds to the wrap, then LOCKED falls, then slots last 4 cycles. LOCKED re-asserts after 16 new 32-cycle periods.
- Stretch (CLK_STRETCH_EN defined). NUM_OUT=2, DIV=1, STRETCH high for 5 cycles at the end of slot 1 → CLK_OUT frozen at 11, no pulses, period becomes 13 cycles.
- Stretch compiled out (CLK_STRETCH_EN undefined). Same stimulus → period stays 8 cycles.
- Reset mid-period. RESET high for 1 cycle at slot 3, NUM_OUT=2 → outputs and LOCKED held 0; restart at slot 0 with CLK_EN_RISE[0] on the next edge.
